// File: rtl/block_xfer_pkg.sv
// Shared types and constants for the LDM/STM block transfer sequencer.
package block_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int WORD_BYTES = 4;

  // Addressing modes encoded as {P, U}.
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/block_xfer_if.sv
// Decode, memory and register-file signals of the block transfer sequencer.
// Memory handshake: mem_req is valid, mem_ack completes the beat in that same
// cycle; mem_we/mem_addr/mem_wdata/reg_idx hold steady until the acked cycle.
interface block_xfer_if #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
);
  logic                start;
  logic [NUM_REGS-1:0] reg_list;
  logic [IDX_W-1:0]    base_idx;
  logic [ADDR_W-1:0]   base_val;
  logic                p_flag;
  logic                u_flag;
  logic                w_flag;
  logic                l_flag;
  logic [ADDR_W-1:0]   st_data;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [ADDR_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [ADDR_W-1:0]   mem_rdata;
  logic                mem_abort;
  logic [IDX_W-1:0]    reg_idx;
  logic                reg_we;
  logic [ADDR_W-1:0]   reg_wdata;
  logic                wb_we;
  logic [ADDR_W-1:0]   wb_val;
  logic                busy;
  logic                done;
  logic                aborted;

  modport master (
    input  start, reg_list, base_idx, base_val, p_flag, u_flag, w_flag, l_flag,
           st_data, mem_ack, mem_rdata, mem_abort,
    output mem_req, mem_we, mem_addr, mem_wdata, reg_idx, reg_we, reg_wdata,
           wb_we, wb_val, busy, done, aborted
  );

  modport slave (
    output start, reg_list, base_idx, base_val, p_flag, u_flag, w_flag, l_flag,
           st_data, mem_ack, mem_rdata, mem_abort,
    input  mem_req, mem_we, mem_addr, mem_wdata, reg_idx, reg_we, reg_wdata,
           wb_we, wb_val, busy, done, aborted
  );
endinterface

// File: rtl/block_xfer_ffs.sv
// Find-first-set (lowest index) plus popcount over a register list.
module block_xfer_ffs #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    idx   = '0;
    count = '0;
    // Scanning downward leaves the lowest set index as the final assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    for (int i = 0; i < N; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/block_xfer_sequencer.sv
// ARM LDM/STM block transfer sequencer: walks the register list lowest-first.
// Optional abort handling is compiled in with `define BLOCK_XFER_ABORT_EN.
module block_xfer_sequencer
  import block_xfer_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic         clk,
  input  logic         rst,
  block_xfer_if.master bus,
  output state_t       dbg_state
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);
  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(WORD_BYTES);

  state_t              state;
  logic [NUM_REGS-1:0] rem;
  logic [NUM_REGS-1:0] list_q;
  logic [IDX_W-1:0]    base_idx_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [ADDR_W-1:0]   wb_val_q;
  logic [CNT_W-1:0]    n_q;
  logic                p_q, u_q, w_q, l_q;
  logic                mem_req_q, mem_we_q, wb_we_q, busy_q, done_q;

  logic [IDX_W-1:0]    ffs_idx;
  logic                ffs_valid;
  logic [CNT_W-1:0]    ffs_cnt;
  logic [ADDR_W-1:0]   setup_span, n_span, start_addr;
  logic                beat, abort_beat, last_beat;

  block_xfer_ffs #(.N(NUM_REGS), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_ffs (
    .vec   (rem),
    .idx   (ffs_idx),
    .valid (ffs_valid),
    .count (ffs_cnt)
  );

  // In SETUP the remaining list still equals the full list, so ffs_cnt is n.
  assign setup_span = ADDR_W'(ffs_cnt) * WORD;
  assign n_span     = ADDR_W'(n_q) * WORD;
  assign beat       = mem_req_q & bus.mem_ack;
  assign last_beat  = (ffs_cnt == CNT_W'(1));

  always_comb begin
    start_addr = base_q;
    unique case ({p_q, u_q})
      MODE_IA: start_addr = base_q;
      MODE_IB: start_addr = base_q + WORD;
      MODE_DA: start_addr = base_q - setup_span + WORD;
      MODE_DB: start_addr = base_q - setup_span;
      default: start_addr = base_q;
    endcase
  end

`ifdef BLOCK_XFER_ABORT_EN
  logic aborted_q;
  assign abort_beat  = beat & bus.mem_abort;
  assign bus.aborted = aborted_q;
`else
  logic unused_abort;
  assign unused_abort = bus.mem_abort;
  assign abort_beat   = 1'b0;
  assign bus.aborted  = 1'b0;
`endif

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_req_q ? bus.st_data : '0;
  assign bus.reg_idx   = mem_req_q ? ffs_idx : '0;
  assign bus.reg_we    = beat & l_q & ~abort_beat;
  assign bus.reg_wdata = (mem_req_q & l_q) ? bus.mem_rdata : '0;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_val    = wb_val_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      list_q     <= '0;
      base_idx_q <= '0;
      base_q     <= '0;
      mem_addr_q <= '0;
      wb_val_q   <= '0;
      n_q        <= '0;
      p_q        <= 1'b0;
      u_q        <= 1'b0;
      w_q        <= 1'b0;
      l_q        <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      wb_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BLOCK_XFER_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            rem        <= bus.reg_list;
            list_q     <= bus.reg_list;
            base_idx_q <= bus.base_idx;
            base_q     <= bus.base_val & ~ADDR_W'(WORD_BYTES - 1);
            p_q        <= bus.p_flag;
            u_q        <= bus.u_flag;
            w_q        <= bus.w_flag;
            l_q        <= bus.l_flag;
            busy_q     <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          n_q <= ffs_cnt;
          if (ffs_valid) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= ~l_q;
            mem_addr_q <= start_addr;
            state      <= XFER;
          end else begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        XFER: begin
          if (beat) begin
`ifdef BLOCK_XFER_ABORT_EN
            if (abort_beat) begin
              mem_req_q  <= 1'b0;
              mem_we_q   <= 1'b0;
              mem_addr_q <= '0;
              rem        <= '0;
              done_q     <= 1'b1;
              aborted_q  <= 1'b1;
              state      <= DONE;
            end else
`endif
            begin
              rem <= rem & ~(NUM_REGS'(1) << ffs_idx);
              if (last_beat) begin
                mem_req_q  <= 1'b0;
                mem_we_q   <= 1'b0;
                mem_addr_q <= '0;
                // A loaded base register takes priority over writeback.
                wb_we_q    <= w_q & ~(l_q & list_q[base_idx_q]);
                wb_val_q   <= u_q ? base_q + n_span : base_q - n_span;
                state      <= WB;
              end else begin
                mem_addr_q <= mem_addr_q + WORD;
              end
            end
          end
        end
        WB: begin
          wb_we_q  <= 1'b0;
          wb_val_q <= '0;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
`ifdef BLOCK_XFER_ABORT_EN
          aborted_q <= 1'b0;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_xfer_sequencer.sv
// Self-checking bench for block_xfer_sequencer: reference address model,
// scoreboard of expected beats, and a memory responder with programmable wait.
module tb_block_xfer_sequencer;
  import block_xfer_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks;
  int     errors;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_idx_q[$];

  block_xfer_if #(.NUM_REGS(16), .ADDR_W(32)) bus ();

  block_xfer_sequencer #(.NUM_REGS(16), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_req"},   32'(bus.mem_req),   0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    0);
    check({tag, "_mem_addr"},  bus.mem_addr,       0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,      0);
    check({tag, "_reg_idx"},   32'(bus.reg_idx),   0);
    check({tag, "_reg_we"},    32'(bus.reg_we),    0);
    check({tag, "_reg_wdata"}, bus.reg_wdata,      0);
    check({tag, "_wb_we"},     32'(bus.wb_we),     0);
    check({tag, "_wb_val"},    bus.wb_val,         0);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_done"},      32'(bus.done),      0);
    check({tag, "_aborted"},   32'(bus.aborted),   0);
    check({tag, "_state"},     32'(dbg_state),     32'(IDLE));
  endtask

  task automatic drive_start(input logic [15:0] list, input logic [3:0] bidx,
                             input logic [31:0] base, input logic p, input logic u,
                             input logic w, input logic l);
    bus.start    = 1'b1;
    bus.reg_list = list;
    bus.base_idx = bidx;
    bus.base_val = base;
    bus.p_flag   = p;
    bus.u_flag   = u;
    bus.w_flag   = w;
    bus.l_flag   = l;
    @(posedge clk);
    #1;
    // Scramble decode inputs: the sequencer must work from its latched copy.
    bus.start    = 1'b0;
    bus.reg_list = 16'($urandom);
    bus.base_idx = 4'($urandom);
    bus.base_val = $urandom;
    bus.p_flag   = 1'($urandom);
    bus.u_flag   = 1'($urandom);
    bus.w_flag   = 1'($urandom);
    bus.l_flag   = 1'($urandom);
  endtask

  // Drives one transfer, scoreboards every beat, checks writeback and timing.
  task automatic run_xfer(input string name, input logic [15:0] list, input logic [3:0] bidx,
                          input logic [31:0] base, input logic p, input logic u,
                          input logic w, input logic l, input int wait_cyc,
                          input int abort_at, input bit mid_start);
    int          n, cyc, beats, waited, wb_seen, exp_done;
    logic [31:0] b, addr, exp_wb_val, wb_got;
    bit          exp_wb_we, exp_ab, abort_this, fin;

    b = base & 32'hFFFF_FFFC;
    n = $countones(list);
    case ({p, u})
      2'b01:   addr = b;
      2'b11:   addr = b + 32'd4;
      2'b00:   addr = b - 32'(4 * n) + 32'd4;
      default: addr = b - 32'(4 * n);
    endcase
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        exp_addr_q.push_back(addr);
        exp_idx_q.push_back(32'(i));
        addr = addr + 32'd4;
      end
    end
    exp_ab = 1'b0;
`ifdef BLOCK_XFER_ABORT_EN
    if (abort_at >= 0 && abort_at < n) exp_ab = 1'b1;
`endif
    exp_wb_val = u ? b + 32'(4 * n) : b - 32'(4 * n);
    exp_wb_we  = (n > 0) && w && !(l && list[bidx]) && !exp_ab;
    if (n == 0)      exp_done = 2;
    else if (exp_ab) exp_done = 2 + abort_at * (wait_cyc + 1) + wait_cyc + 1;
    else             exp_done = n * (wait_cyc + 1) + 3;

    drive_start(list, bidx, base, p, u, w, l);
    cyc = 1;
    check({name, "_busy_rise"}, 32'(bus.busy), 1);

    beats = 0; waited = 0; wb_seen = 0; wb_got = '0; fin = 1'b0;
    while (!fin) begin
      bus.mem_ack   = 1'b0;
      bus.mem_abort = 1'b0;
      if (mid_start && cyc == 3) begin
        bus.start    = 1'b1;
        bus.reg_list = 16'hFFFF;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.mem_req) begin
        if (exp_addr_q.size() == 0) begin
          check({name, "_extra_req"}, 1, 0);
          fin = 1'b1;
        end else begin
          abort_this    = exp_ab && (beats == abort_at);
          bus.st_data   = $urandom;
          bus.mem_rdata = $urandom;
          bus.mem_ack   = (waited == wait_cyc);
          bus.mem_abort = bus.mem_ack && (beats == abort_at);
          #1;
          check({name, "_addr"}, bus.mem_addr, exp_addr_q[0]);
          check({name, "_idx"},  32'(bus.reg_idx), exp_idx_q[0]);
          check({name, "_we"},   32'(bus.mem_we), 32'(!l));
          if (!l) check({name, "_wdata"}, bus.mem_wdata, bus.st_data);
          if (bus.mem_ack) begin
            check({name, "_reg_we"}, 32'(bus.reg_we), 32'(l && !abort_this));
            if (l && !abort_this) check({name, "_reg_wdata"}, bus.reg_wdata, bus.mem_rdata);
            void'(exp_addr_q.pop_front());
            void'(exp_idx_q.pop_front());
            beats++;
            waited = 0;
            if (abort_this) begin
              exp_addr_q.delete();
              exp_idx_q.delete();
            end
          end else begin
            check({name, "_reg_we_wait"}, 32'(bus.reg_we), 0);
            waited++;
          end
        end
      end
      if (bus.wb_we) begin
        wb_seen++;
        wb_got = bus.wb_val;
      end
      if (bus.done) begin
        check({name, "_done_cyc"}, 32'(cyc), 32'(exp_done));
        check({name, "_aborted"},  32'(bus.aborted), 32'(exp_ab));
        check({name, "_beats_left"}, 32'(exp_addr_q.size()), 0);
        check({name, "_wb_count"}, 32'(wb_seen), 32'(exp_wb_we));
        if (exp_wb_we) check({name, "_wb_val"}, wb_got, exp_wb_val);
        fin = 1'b1;
      end
      if (cyc > 300) begin
        check({name, "_timeout"}, 32'(cyc), 32'(exp_done));
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    exp_addr_q.delete();
    exp_idx_q.delete();
    bus.start     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_abort = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_busy_fall"}, 32'(bus.busy), 0);
    check({name, "_done_fall"}, 32'(bus.done), 0);
    check({name, "_req_idle"},  32'(bus.mem_req), 0);
    @(posedge clk);
    #1;
  endtask

  // Starts a load, holds off the ack, then resets in the middle of XFER.
  task automatic reset_mid_xfer();
    drive_start(16'h00F0, 4'd0, 32'h0000_6000, 1'b0, 1'b1, 1'b1, 1'b1);
    bus.st_data   = 32'hDEAD_BEEF;
    bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rstmid_req_before", 32'(bus.mem_req), 1);
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    check_zero("rstmid");
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.reg_list = '0; bus.base_idx = '0; bus.base_val = '0;
    bus.p_flag = 1'b0; bus.u_flag = 1'b0; bus.w_flag = 1'b0; bus.l_flag = 1'b0;
    bus.st_data = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.mem_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    //        name       list      bidx   base          p     u     w     l   wait abort mid
    run_xfer("stm_ia",   16'h000E, 4'd13, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1, 1'b0);
    run_xfer("ldm_db",   16'h8001, 4'd13, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b1, 0, -1, 1'b0);
    run_xfer("ldm_ib",   16'h0012, 4'd4,  32'h0000_3000, 1'b1, 1'b1, 1'b1, 1'b1, 0, -1, 1'b0);
    run_xfer("empty",    16'h0000, 4'd2,  32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 0, -1, 1'b0);
    run_xfer("stm_da_w", 16'h0505, 4'd13, 32'h0000_4002, 1'b0, 1'b0, 1'b1, 1'b0, 3, -1, 1'b1);
    run_xfer("ldm_wrap", 16'h0003, 4'd13, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 1'b1, 1, -1, 1'b0);
    run_xfer("abort",    16'h00F0, 4'd0,  32'h0000_5000, 1'b0, 1'b1, 1'b1, 1'b1, 0,  1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      run_xfer("rand", 16'($urandom_range(0, 16'hFFFF)), 4'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 2), -1, 1'b0);
    end

    reset_mid_xfer();
    run_xfer("post_rst", 16'h0101, 4'd0, 32'h0000_7000, 1'b0, 1'b1, 1'b1, 1'b1, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
